// File: rtl/ifetch.sv
// Instruction fetch stage: request PC, single-outstanding imem handshake,
// small {addr,inst} buffer in front of the IF/ID flop, redirect handling.
//
// state   | meaning
// --------+---------------------------------------------------------------
// FETCH   | no response outstanding; request pc_q when the buffer has room
// WAIT    | one granted request outstanding; response goes into the buffer
// DISCARD | redirected while a response was outstanding; drop that response
module ifetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    input  logic        stall_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic [31:0]    pend_addr_q, pend_addr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    addr_mem_q [FIFO_DEPTH];
    logic [31:0]    addr_mem_d [FIFO_DEPTH];
    logic [31:0]    data_mem_q [FIFO_DEPTH];
    logic [31:0]    data_mem_d [FIFO_DEPTH];

    logic           fifo_wr;
    logic           fifo_pop;
    logic [CW:0]    cnt_after;
    logic           room;
    logic           can_issue;
    logic           handshake;
    logic [31:0]    redirect_pc;

    // Head-of-buffer presentation and the request decision.
    always_comb begin
        inst_valid_o = (cnt_q != '0);
        inst_o       = inst_valid_o ? data_mem_q[rd_ptr_q] : NOP;
        inst_addr_o  = inst_valid_o ? addr_mem_q[rd_ptr_q] : pc_q;
        fifo_pop     = inst_valid_o & ~stall_i;
        fifo_wr      = (state_q == S_WAIT) & imem_rvalid_i & ~redirect_i;
        // Occupancy after this edge; a request reserves the slot its response will use.
        cnt_after    = {1'b0, cnt_q} + (CW+1)'(fifo_wr) - (CW+1)'(fifo_pop);
        room         = (cnt_after < (CW+1)'(FIFO_DEPTH));
        can_issue    = (state_q == S_FETCH) | ((state_q == S_WAIT) & imem_rvalid_i);
        imem_req_o   = ~rst & ~redirect_i & can_issue & room;
        imem_addr_o  = pc_q;
        handshake    = imem_req_o & imem_gnt_i;
        redirect_pc  = redirect_addr_i & 32'hFFFF_FFFC;
    end

    // Next-state for FSM, PC, outstanding address and buffer.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_addr_d = pend_addr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_after[CW-1:0];
        addr_mem_d  = addr_mem_q;
        data_mem_d  = data_mem_q;

        if (fifo_wr) begin
            addr_mem_d[wr_ptr_q] = pend_addr_q;
            data_mem_d[wr_ptr_q] = imem_rdata_i;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (handshake) begin
            pend_addr_d = pc_q;
            pc_d        = pc_q + 32'd4;
        end

        case (state_q)
            S_FETCH: begin
                if (handshake) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid_i) state_d = handshake ? S_WAIT : S_FETCH;
                else if (redirect_i) state_d = S_DISCARD;
            end
            S_DISCARD: begin
                if (imem_rvalid_i) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Redirect flushes the buffer and overrides any pop/write this cycle.
        if (redirect_i) begin
            pc_d     = redirect_pc;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            pend_addr_q <= RESET_PC;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            addr_mem_q  <= '{default: '0};
            data_mem_q  <= '{default: '0};
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_addr_q <= pend_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            addr_mem_q  <= addr_mem_d;
            data_mem_q  <= data_mem_d;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: memory responder with configurable latency,
// scoreboard of delivered {addr,inst} pairs, and targeted cycle checks.
module tb_ifetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        stall_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;

    int checks   = 0;
    int failures = 0;

    logic [63:0] sb_q [$];
    logic        pend_valid;
    logic        pend_drop;
    int          pend_cnt;
    logic [31:0] pend_addr;
    int          lat;

    logic        s_req, s_valid, s_grant;
    logic [31:0] s_addr, s_inst, s_iaddr;
    logic        found;
    logic [31:0] head;

    always #5 clk = ~clk;

    ifetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_gnt_i     (imem_gnt_i),
        .imem_rvalid_i  (imem_rvalid_i),
        .imem_rdata_i   (imem_rdata_i),
        .redirect_i     (redirect_i),
        .redirect_addr_i(redirect_addr_i),
        .stall_i        (stall_i),
        .inst_o         (inst_o),
        .inst_addr_o    (inst_addr_o),
        .inst_valid_o   (inst_valid_o)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A3C_0F01;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, score, then drive memory response after posedge.
    task automatic step();
        logic [63:0] e;
        @(negedge clk);
        s_req   = imem_req_o;
        s_addr  = imem_addr_o;
        s_valid = inst_valid_o;
        s_inst  = inst_o;
        s_iaddr = inst_addr_o;
        s_grant = imem_req_o & imem_gnt_i;

        if (s_valid && !stall_i) begin
            chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_addr", s_iaddr, e[63:32]);
                chk("sb_inst", s_inst, e[31:0]);
            end
        end
        if (!s_valid) chk("nop_when_empty", s_inst, NOP);

        if (rst || redirect_i) sb_q.delete();
        if (imem_rvalid_i && pend_valid) begin
            if (!pend_drop && !rst && !redirect_i)
                sb_q.push_back({pend_addr, mem_word(pend_addr)});
            pend_valid = 1'b0;
        end else if (pend_valid && (rst || redirect_i)) begin
            pend_drop = 1'b1;
        end
        if (s_grant) begin
            pend_valid = 1'b1;
            pend_drop  = 1'b0;
            pend_cnt   = lat;
            pend_addr  = s_addr;
        end

        @(posedge clk);
        #1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'hDEAD_BEEF;
        if (pend_valid) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem_word(pend_addr);
            end
        end
    endtask

    task automatic wait_valid(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (s_valid) got = 1'b1;
        end
        chk(tag, 32'(got), 32'd1);
    endtask

    task automatic wait_grant(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (s_grant) got = 1'b1;
        end
        chk(tag, 32'(got), 32'd1);
    endtask

    initial begin
        rst = 1'b1; imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = 32'hDEAD_BEEF;
        redirect_i = 1'b0; redirect_addr_i = 32'h0; stall_i = 1'b0; lat = 1;
        pend_valid = 1'b0; pend_drop = 1'b0; pend_cnt = 0; pend_addr = 32'h0;
        @(posedge clk); #1;
        step(); step();
        chk("rst_req", 32'(s_req), 32'd0);
        chk("rst_addr", s_addr, RESET_PC);
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_inst", s_inst, NOP);
        chk("rst_iaddr", s_iaddr, RESET_PC);

        // Zero-wait streaming after reset release
        rst = 1'b0;
        step();
        chk("t1_req_c0", 32'(s_req), 32'd1);
        chk("t1_addr_c0", s_addr, 32'h0);
        step();
        chk("t1_req_c1", 32'(s_req), 32'd1);
        chk("t1_addr_c1", s_addr, 32'h4);
        step();
        chk("t1_valid_c2", 32'(s_valid), 32'd1);
        chk("t1_iaddr_c2", s_iaddr, 32'h0);
        chk("t1_inst_c2", s_inst, mem_word(32'h0));
        step();
        chk("t1_iaddr_c3", s_iaddr, 32'h4);
        step();
        chk("t1_iaddr_c4", s_iaddr, 32'h8);
        repeat (3) step();

        // Stall for 5 cycles: buffer fills, request drops, head held
        stall_i = 1'b1;
        step();
        head = s_iaddr;
        chk("t2_valid_stall", 32'(s_valid), 32'd1);
        repeat (4) step();
        chk("t2_req_dropped", 32'(s_req), 32'd0);
        chk("t2_head_held", s_iaddr, head);
        stall_i = 1'b0;
        step();
        chk("t2_resume_head", s_iaddr, head);
        repeat (6) step();

        // Redirect while a slow response is outstanding
        lat = 3;
        wait_grant("t3_grant_seen");
        redirect_i = 1'b1; redirect_addr_i = 32'h100; lat = 1;
        step();
        redirect_i = 1'b0;
        chk("t3_redirect_noreq", 32'(s_req), 32'd0);
        step();
        chk("t3_flushed", 32'(s_valid), 32'd0);
        step();
        chk("t3_discard_noreq", 32'(s_req), 32'd0);
        step();
        chk("t3_req_after", 32'(s_req), 32'd1);
        chk("t3_addr_0x100", s_addr, 32'h100);
        wait_valid("t3_valid_timeout");
        chk("t3_first_iaddr", s_iaddr, 32'h100);
        repeat (4) step();

        // Redirect coincident with rvalid; low address bits ignored
        redirect_i = 1'b1; redirect_addr_i = 32'h203;
        step();
        redirect_i = 1'b0;
        chk("t4_redirect_noreq", 32'(s_req), 32'd0);
        step();
        chk("t4_req", 32'(s_req), 32'd1);
        chk("t4_addr_0x200", s_addr, 32'h200);
        wait_valid("t4_valid_timeout");
        chk("t4_first_iaddr", s_iaddr, 32'h200);
        chk("t4_first_inst", s_inst, mem_word(32'h200));
        repeat (3) step();

        // Grant withheld at top of address space, then wrap
        redirect_i = 1'b1; redirect_addr_i = 32'hFFFF_FFFC; imem_gnt_i = 1'b0;
        step();
        redirect_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_req_held", 32'(s_req), 32'd1);
            chk("t5_addr_held", s_addr, 32'hFFFF_FFFC);
        end
        imem_gnt_i = 1'b1;
        step();
        chk("t5_grant_addr", s_addr, 32'hFFFF_FFFC);
        step();
        chk("t5_wrap_addr", s_addr, 32'h0);
        wait_valid("t5_valid_timeout");
        chk("t5_first_iaddr", s_iaddr, 32'hFFFF_FFFC);
        step();
        chk("t5_wrap_iaddr", s_iaddr, 32'h0);
        repeat (3) step();

        // Reset while waiting; stale response after release must be ignored
        lat = 3;
        wait_grant("t6_grant_seen");
        rst = 1'b1; lat = 1;
        step();
        rst = 1'b0; imem_gnt_i = 1'b0;
        step();
        chk("t6_req_resetpc", 32'(s_req), 32'd1);
        chk("t6_addr_resetpc", s_addr, RESET_PC);
        step();
        step();
        chk("t6_stale_dropped", 32'(s_valid), 32'd0);
        chk("t6_addr_still", s_addr, RESET_PC);
        imem_gnt_i = 1'b1;
        wait_valid("t6_valid_timeout");
        chk("t6_first_iaddr", s_iaddr, RESET_PC);
        chk("t6_first_inst", s_inst, mem_word(RESET_PC));
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
